// File: rtl/mant_div_seq.sv
// Sequential radix-2 restoring mantissa divider: one quotient bit per cycle, MSB first,
// with sticky/normalize flags for the rounding stage and divide-by-zero detection.
module mant_div_seq #(
   parameter int N     = 24,
   parameter int GUARD = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     dividend,
   input  logic [N-1:0]     divisor,
   output logic             busy,
   output logic             valid,
   output logic [N+GUARD:0] quotient,
   output logic [N:0]       remainder,
   output logic             sticky,
   output logic             normalize,
   output logic             div_by_zero
);

   localparam int QW = N + GUARD + 1;
   localparam int CW = $clog2(QW);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t        state;
   logic [N-1:0]  div;
   logic [N:0]    rem;
   logic [CW-1:0] cnt;

   logic          rem_ge;
   logic [N:0]    rem_sub;
   logic [N:0]    rem_after;
   logic [N:0]    rem_next;

   // rem stays below 2*div, so the restored/subtracted value always fits in N bits
   // before the shift and the shifted value fits in N+1 bits.
   always_comb begin
      rem_ge    = (rem >= {1'b0, div});
      rem_sub   = rem - {1'b0, div};
      rem_after = rem_ge ? rem_sub : rem;
      rem_next  = {rem_after[N-1:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         div         <= '0;
         rem         <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         valid       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         sticky      <= 1'b0;
         normalize   <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  busy      <= 1'b1;
                  remainder <= '0;
                  sticky    <= 1'b0;
                  normalize <= 1'b0;
                  if (divisor[N-1]) begin
                     div         <= divisor;
                     rem         <= {1'b0, dividend};
                     cnt         <= CW'(QW - 1);
                     quotient    <= '0;
                     div_by_zero <= 1'b0;
                     state       <= CALC;
                  end else begin
                     quotient    <= '1;
                     div_by_zero <= 1'b1;
                     valid       <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            CALC: begin
               quotient <= {quotient[QW-2:0], rem_ge};
               rem      <= rem_next;
               if (cnt == '0) begin
                  // The bit now entering position QW-1 was shifted in first: it is the integer bit.
                  remainder   <= rem_after;
                  sticky      <= |rem_after;
                  normalize   <= ~quotient[QW-2];
                  div_by_zero <= 1'b0;
                  valid       <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               valid <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               valid <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
